// File: rtl/sensor_window_features_if.sv
// sensor_window_features_if: feature-vector valid/ready channel from the window stage to the tree scorer.
interface sensor_window_features_if #(parameter int CNT_W = 7);
    logic             feat_valid;
    logic             feat_ready;
    logic [CNT_W-1:0] feat_high_cnt;
    logic [CNT_W-1:0] feat_edge_cnt;
    logic [CNT_W-1:0] feat_max_run;
    logic             feat_overrun;
    modport master (output feat_valid, feat_high_cnt, feat_edge_cnt, feat_max_run, feat_overrun,
                    input feat_ready);
    modport slave (input feat_valid, feat_high_cnt, feat_edge_cnt, feat_max_run, feat_overrun,
                   output feat_ready);
endinterface

// File: rtl/sensor_window_features.sv
// sensor_window_features: synchronises a raw sensor bit and emits per-window high/edge/max-run features.
module sensor_window_features #(
    parameter int WINDOW = 64,
    parameter int CNT_W  = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_input,
    sensor_window_features_if.master feat
);
    logic             s1_q, s1_d, s2_q, s2_d, prev_q, prev_d;
    logic [CNT_W-1:0] win_q, win_d, high_q, high_d, rise_q, rise_d, run_q, run_d, max_q, max_d;
    logic [CNT_W-1:0] o_high_q, o_high_d, o_rise_q, o_rise_d, o_max_q, o_max_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    logic [CNT_W-1:0] high_n, rise_n, run_n, max_n;
    logic             win_end, load;

    always_comb begin
        s1_d      = sensor_input;
        s2_d      = s1_q;
        prev_d    = s2_q;
        win_end   = win_q == CNT_W'(WINDOW - 1);
        high_n    = high_q + CNT_W'(s2_q);
        rise_n    = rise_q + CNT_W'(s2_q & ~prev_q);
        run_n     = s2_q ? run_q + CNT_W'(1) : '0;
        max_n     = run_n > max_q ? run_n : max_q;
        // A finished window is taken only if the output slot is free or being drained now.
        load      = win_end & (~valid_q | feat.feat_ready);
        win_d     = win_end ? '0 : win_q + CNT_W'(1);
        high_d    = win_end ? '0 : high_n;
        rise_d    = win_end ? '0 : rise_n;
        run_d     = win_end ? '0 : run_n;
        max_d     = win_end ? '0 : max_n;
        o_high_d  = load ? high_n : o_high_q;
        o_rise_d  = load ? rise_n : o_rise_q;
        o_max_d   = load ? max_n : o_max_q;
        valid_d   = load | (valid_q & ~feat.feat_ready);
        overrun_d = overrun_q | (win_end & ~load);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            {s1_q, s2_q, prev_q, valid_q, overrun_q} <= '0;
            {win_q, high_q, rise_q, run_q, max_q}    <= '0;
            {o_high_q, o_rise_q, o_max_q}            <= '0;
        end else begin
            {s1_q, s2_q, prev_q, valid_q, overrun_q} <= {s1_d, s2_d, prev_d, valid_d, overrun_d};
            {win_q, high_q, rise_q, run_q, max_q}    <= {win_d, high_d, rise_d, run_d, max_d};
            {o_high_q, o_rise_q, o_max_q}            <= {o_high_d, o_rise_d, o_max_d};
        end
    end

    assign feat.feat_valid    = valid_q;
    assign feat.feat_high_cnt = o_high_q;
    assign feat.feat_edge_cnt = o_rise_q;
    assign feat.feat_max_run  = o_max_q;
    assign feat.feat_overrun  = overrun_q;
endmodule

// File: tb/tb_sensor_window_features.sv
// tb_sensor_window_features: random and directed stimulus checked against a window-level reference model.
module tb_sensor_window_features;
    localparam int WINDOW = 64;
    localparam int CNT_W  = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sensor_input = 1'b0;
    sensor_window_features_if #(.CNT_W(CNT_W)) feat ();

    sensor_window_features #(.WINDOW(WINDOW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .sensor_input(sensor_input), .feat(feat.master)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 0;

    // Reference model: raw input history, synced-sample history, and the output slot.
    bit in_h [4096];
    bit s_h  [4096];
    int t = 0;
    bit ev = 0, eo = 0;
    int eh = 0, ee = 0, em = 0;

    task automatic chk(string nm, int act, int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0d: got %0d expected %0d", nm, t, act, exp);
        end
    endtask

    always @(negedge clk) if (chk_en) begin
        chk("valid", int'(feat.feat_valid), int'(ev));
        chk("overrun", int'(feat.feat_overrun), int'(eo));
        chk("high", int'(feat.feat_high_cnt), eh);
        chk("edge", int'(feat.feat_edge_cnt), ee);
        chk("max_run", int'(feat.feat_max_run), em);
    end

    // Features of the window ending at cycle te, straight from the sample history.
    task automatic window_feats(input int te, output int h, output int e, output int m);
        int run;
        h = 0; e = 0; m = 0; run = 0;
        for (int i = te - WINDOW + 1; i <= te; i++) begin
            bit s, p;
            s = s_h[i];
            p = (i > 0) ? s_h[i-1] : 1'b0;
            h += int'(s);
            e += int'(s & ~p);
            run = s ? run + 1 : 0;
            if (run > m) m = run;
        end
    endtask

    task automatic step(input bit din, input bit rdy, input bit rst);
        sensor_input    = din;
        feat.feat_ready = rdy;
        reset           = rst;
        if (rst) begin
            t = 0; ev = 0; eo = 0; eh = 0; ee = 0; em = 0;
        end else begin
            bit we, ld;
            s_h[t]  = (t >= 2) ? in_h[t-2] : 1'b0;
            in_h[t] = din;
            we = (t % WINDOW) == WINDOW - 1;
            ld = we && (!ev || rdy);
            if (ld) begin
                window_feats(t, eh, ee, em);
                ev = 1;
            end else if (ev && rdy) ev = 0;
            if (we && !ld) eo = 1;
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        bit cur, rdy;
        int rmode, flip;
        feat.feat_ready = 1'b1;
        step(0, 1, 1);
        chk_en = 1;
        chk("reset_valid", int'(feat.feat_valid), 0);
        chk("reset_overrun", int'(feat.feat_overrun), 0);
        // Idle input: single-cycle valid pulses with zero features.
        for (int i = 0; i < 64; i++) step(0, 1, 0);
        chk("idle_valid_rise", int'(feat.feat_valid), 1);
        chk("idle_high", int'(feat.feat_high_cnt), 0);
        step(0, 1, 0);
        chk("idle_valid_pulse", int'(feat.feat_valid), 0);
        for (int i = 0; i < 63; i++) step(0, 1, 0);
        chk("idle_valid_2nd", int'(feat.feat_valid), 1);
        // Input held high through reset release.
        step(1, 1, 1);
        for (int i = 0; i < 64; i++) step(1, 1, 0);
        chk("hold_w0_high", int'(feat.feat_high_cnt), 62);
        chk("hold_w0_edge", int'(feat.feat_edge_cnt), 1);
        chk("hold_w0_run", int'(feat.feat_max_run), 62);
        for (int i = 0; i < 64; i++) step(1, 1, 0);
        chk("hold_w1_high", int'(feat.feat_high_cnt), 64);
        chk("hold_w1_edge", int'(feat.feat_edge_cnt), 0);
        chk("hold_w1_run", int'(feat.feat_max_run), 64);
        // Toggling input, steady state.
        step(0, 1, 1);
        for (int i = 0; i < 192; i++) step(i[0], 1, 0);
        chk("tog_high", int'(feat.feat_high_cnt), 32);
        chk("tog_edge", int'(feat.feat_edge_cnt), 32);
        chk("tog_run", int'(feat.feat_max_run), 1);
        // Back-pressure for three windows.
        step(1, 0, 1);
        for (int i = 0; i < 64; i++) step(1, 0, 0);
        chk("bp_overrun_w0", int'(feat.feat_overrun), 0);
        for (int i = 0; i < 64; i++) step(1, 0, 0);
        chk("bp_overrun_w1", int'(feat.feat_overrun), 1);
        for (int i = 0; i < 64; i++) step(1, 0, 0);
        chk("bp_held_high", int'(feat.feat_high_cnt), 62);
        chk("bp_held_run", int'(feat.feat_max_run), 62);
        chk("bp_valid", int'(feat.feat_valid), 1);
        step(1, 1, 0);
        chk("bp_valid_drop", int'(feat.feat_valid), 0);
        // Mid-window reset at win_cnt 30.
        while (t % WINDOW != 30) step(1, 1, 0);
        step(1, 1, 1);
        chk("mid_rst_valid", int'(feat.feat_valid), 0);
        chk("mid_rst_overrun", int'(feat.feat_overrun), 0);
        for (int i = 0; i < 63; i++) step(0, 1, 0);
        chk("mid_rst_not_yet", int'(feat.feat_valid), 0);
        step(0, 1, 0);
        chk("mid_rst_valid_64", int'(feat.feat_valid), 1);
        // Run crossing a window boundary (synced cycles 60..69).
        step(0, 1, 1);
        for (int i = 0; i < 64; i++) step(i >= 58, 1, 0);
        chk("span_w0_run", int'(feat.feat_max_run), 4);
        chk("span_w0_edge", int'(feat.feat_edge_cnt), 1);
        for (int i = 64; i < 128; i++) step(i <= 67, 1, 0);
        chk("span_w1_run", int'(feat.feat_max_run), 6);
        chk("span_w1_edge", int'(feat.feat_edge_cnt), 0);
        chk("span_w1_high", int'(feat.feat_high_cnt), 6);
        // Randomised traffic with varying burstiness, back-pressure and rare resets.
        step(0, 1, 1);
        cur = 0; rmode = 0; flip = 4;
        for (int i = 0; i < 2500; i++) begin
            if (i % 150 == 0) begin
                rmode = $urandom_range(0, 2);
                flip  = $urandom_range(1, 20);
            end
            if ($urandom_range(0, flip - 1) == 0) cur = ~cur;
            rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
            step(cur, rdy, $urandom_range(0, 599) == 0);
        end
        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
